// File: rtl/tdc_pkg.sv
// Shared types and helpers for the carry-chain TDC channel.
package tdc_pkg;

  localparam int unsigned CARRY4_TAPS = 4;

  // Storage widths for a timestamp; channel parameters must fit within these.
  localparam int unsigned TS_COARSE_MAX = 32;
  localparam int unsigned TS_FINE_MAX   = 16;
  localparam int unsigned MAX_TAPS      = 256;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StBusy
  } tdc_state_e;

  typedef struct packed {
    logic [TS_COARSE_MAX-1:0] coarse;
    logic [TS_FINE_MAX-1:0]   fine;
    logic                     sat;
  } tdc_ts_t;

  function automatic int unsigned popcount(input logic [MAX_TAPS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_TAPS; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tdc_carry_chain.sv
// Tapped delay line: NCARRY4 cascaded CARRY4 cells, hit enters on CYINIT of the first cell.
module tdc_carry_chain
  import tdc_pkg::*;
#(
  parameter int unsigned NCARRY4 = 16
) (
  input  logic                           hit,
  output logic [CARRY4_TAPS*NCARRY4-1:0] taps
);

  for (genvar g = 0; g < NCARRY4; g++) begin : g_cell
    logic       ci;
    logic       cyinit;
    logic [3:0] s;
    logic [3:0] di;
    logic [3:0] co;

    assign s  = 4'hF;
    assign di = 4'h0;

    if (g == 0) begin : g_head
      assign ci     = 1'b0;
      assign cyinit = hit;
    end else begin : g_link
      assign ci     = g_cell[g-1].co[3];
      assign cyinit = 1'b0;
    end

    // CARRY4 carry mux: each stage propagates when S=1, else loads DI.
    always_comb begin
      logic c;
      c = ci | cyinit;
      for (int j = 0; j < 4; j++) begin
        c     = s[j] ? c : di[j];
        co[j] = c;
      end
    end

    assign taps[CARRY4_TAPS*g +: CARRY4_TAPS] = co;
  end

endmodule

// File: rtl/tdc_carry_chain_channel.sv
// TDC capture channel: chain taps -> 2-flop sync -> edge detect -> one-entry timestamp register.
// Define TDC_BUBBLE_FILTER_EN to majority-filter the taps before the ones count.
module tdc_carry_chain_channel
  import tdc_pkg::*;
#(
  parameter int unsigned NCARRY4  = 16,
  parameter int unsigned COARSE_W = 16,
  parameter int unsigned FINE_W   = $clog2(CARRY4_TAPS * NCARRY4 + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                hit,
  input  logic                ts_ready,
  input  logic                ovf_clr,
  output logic                ts_valid,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FINE_W-1:0]   ts_fine,
  output logic                ts_sat,
  output logic                ovf
);

  localparam int unsigned NTAP = CARRY4_TAPS * NCARRY4;

  logic [NTAP-1:0]     taps;
  logic [NTAP-1:0]     s1;
  logic [NTAP-1:0]     s2;
  logic [NTAP-1:0]     filt;
  logic                p0;
  logic                det;
  logic                capture;
  logic                load;
  logic [COARSE_W-1:0] cc;
  logic [COARSE_W-1:0] cc_d1;
  logic [COARSE_W-1:0] cc_d2;
  int unsigned         ones;
  tdc_state_e          state;
  tdc_ts_t             cap;
  tdc_ts_t             ts_d;
  tdc_ts_t             ts_q;

  tdc_carry_chain #(
    .NCARRY4(NCARRY4)
  ) u_chain (
    .hit (hit),
    .taps(taps)
  );

  // cc_d2 lines up with s2, i.e. the cc value at the edge that loaded s1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      p0    <= 1'b0;
      cc    <= '0;
      cc_d1 <= '0;
      cc_d2 <= '0;
    end else begin
      s1    <= taps;
      s2    <= s1;
      p0    <= s2[0];
      cc    <= cc + COARSE_W'(1);
      cc_d1 <= cc;
      cc_d2 <= cc_d1;
    end
  end

`ifdef TDC_BUBBLE_FILTER_EN
  // Top tap has no upper neighbour; it stands in for itself.
  logic [NTAP:0] s2x;
  assign s2x = {s2[NTAP-1], s2};

  always_comb begin
    filt = s2;
    for (int i = 1; i < NTAP; i++) begin
      filt[i] = (s2x[i-1] & s2x[i]) | (s2x[i-1] & s2x[i+1]) | (s2x[i] & s2x[i+1]);
    end
  end
`else
  assign filt = s2;
`endif

  always_comb begin
    ones       = popcount(MAX_TAPS'(filt));
    cap.coarse = TS_COARSE_MAX'(cc_d2);
    cap.fine   = TS_FINE_MAX'(ones);
    cap.sat    = (ones == NTAP);
  end

  assign det     = s2[0] & ~p0;
  assign capture = (state == StArmed) & det;
  assign load    = capture & (~ts_valid | ts_ready);

  always_comb begin
    ts_d = ts_q;
    if (load) begin
      ts_d = cap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      ts_valid <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        StIdle:  if (en) state <= StArmed;
        StArmed: begin
          if (det) begin
            state <= StBusy;
          end else if (!en) begin
            state <= StIdle;
          end
        end
        StBusy:  if (!s2[0]) state <= en ? StArmed : StIdle;
        default: state <= StIdle;
      endcase

      if (load) begin
        ts_valid <= 1'b1;
      end else if (ts_ready) begin
        ts_valid <= 1'b0;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (capture && ts_valid && !ts_ready) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign ts_coarse = ts_q.coarse[COARSE_W-1:0];
  assign ts_fine   = ts_q.fine[FINE_W-1:0];
  assign ts_sat    = ts_q.sat;

endmodule
